tlb_maint_ctrl: RTL and testbench

//  Sequences TLB maintenance ops (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) from the backend onto the address-translation unit's

---
 rtl/tlb_maint_ctrl.sv | 101 ++++++++++
 tb/tb_tlb_maint_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/tlb_maint_ctrl.sv
// tlb_maint_ctrl: sequences TLB maintenance ops onto the translation unit ports and returns a completion handshake
module tlb_maint_ctrl #(
  parameter int TLBNUM = 32,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [4:0]       req_inv_op,
  input  logic [9:0]       req_inv_asid,
  input  logic [18:0]      req_inv_vpn,
  output logic             tlbwr_en,
  output logic             tlbfill_en,
  output logic [IDX_W-1:0] rand_index,
  output logic             invtlb_en,
  output logic [4:0]       invtlb_op,
  output logic [9:0]       invtlb_asid,
  output logic [18:0]      invtlb_vpn,
  output logic             srch_fetch,
  input  logic             srch_found_in,
  input  logic [IDX_W-1:0] srch_index_in,
  output logic             rd_capture,
  output logic             trans_busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [2:0]       done_op,
  output logic             done_found,
  output logic [IDX_W-1:0] done_index,
  output logic             done_ine,
  output logic             refetch_req
);
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SETTLE, RESP} state_t;
  state_t state, state_nx;
  logic [2:0]       op_q;
  logic [IDX_W-1:0] cnt, idx_q;
  logic             found_q, ine_q, issue, ine_now;
  assign issue   = state == ISSUE;
  assign ine_now = (op_q > OP_INV) || (op_q == OP_INV && invtlb_op > 5'd6);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = req_valid ? ISSUE : IDLE;
      ISSUE:  state_nx = (ine_now || op_q == OP_RD) ? RESP : (op_q == OP_SRCH ? WAIT : SETTLE);
      WAIT:   state_nx = RESP;
      SETTLE: state_nx = RESP;
      RESP:   state_nx = done_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  assign req_ready   = state == IDLE;
  assign trans_busy  = state != IDLE;
  assign srch_fetch  = issue && op_q == OP_SRCH;
  assign rd_capture  = issue && op_q == OP_RD;
  assign tlbwr_en    = issue && op_q == OP_WR;
  assign tlbfill_en  = issue && op_q == OP_FILL;
  assign invtlb_en   = issue && op_q == OP_INV && !ine_now;
  assign rand_index  = tlbfill_en ? cnt : '0;
  assign done_valid  = state == RESP;
  assign done_op     = done_valid ? op_q : 3'd0;
  assign done_found  = done_valid && found_q;
  assign done_index  = done_valid ? idx_q : '0;
  assign done_ine    = done_valid && ine_q;
  assign refetch_req = done_valid && done_ready && !ine_q && (op_q == OP_WR || op_q == OP_FILL || op_q == OP_INV);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      ine_q       <= 1'b0;
      invtlb_op   <= '0;
      invtlb_asid <= '0;
      invtlb_vpn  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (cnt == IDX_W'(TLBNUM - 1)) ? '0 : cnt + 1'b1;
      if (state == IDLE && req_valid) begin
        op_q        <= req_op;
        invtlb_op   <= req_inv_op;
        invtlb_asid <= req_inv_asid;
        invtlb_vpn  <= req_inv_vpn;
        idx_q       <= '0;
        found_q     <= 1'b0;
        ine_q       <= 1'b0;
      end
      if (issue) ine_q <= ine_now;
      if (state == WAIT) begin
        found_q <= srch_found_in;
        idx_q   <= srch_found_in ? srch_index_in : '0;
      end
    end
  end
endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb_tlb_maint_ctrl: randomized transactions against a transaction-level model of the maintenance controller
module tb_tlb_maint_ctrl;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, done_ready = 0, srch_found_in = 0;
  logic [2:0]  req_op = 0;
  logic [4:0]  req_inv_op = 0, srch_index_in = 0;
  logic [9:0]  req_inv_asid = 0;
  logic [18:0] req_inv_vpn = 0;
  logic        req_ready, tlbwr_en, tlbfill_en, invtlb_en, srch_fetch, rd_capture;
  logic        trans_busy, done_valid, done_found, done_ine, refetch_req;
  logic [4:0]  rand_index, invtlb_op, done_index;
  logic [9:0]  invtlb_asid;
  logic [18:0] invtlb_vpn;
  logic [2:0]  done_op;
  int nerr = 0, nchk = 0, ncyc = 0;

  tlb_maint_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vpn(req_inv_vpn),
    .tlbwr_en(tlbwr_en), .tlbfill_en(tlbfill_en), .rand_index(rand_index), .invtlb_en(invtlb_en),
    .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid), .invtlb_vpn(invtlb_vpn),
    .srch_fetch(srch_fetch), .srch_found_in(srch_found_in), .srch_index_in(srch_index_in),
    .rd_capture(rd_capture), .trans_busy(trans_busy), .done_valid(done_valid), .done_ready(done_ready),
    .done_op(done_op), .done_found(done_found), .done_index(done_index), .done_ine(done_ine),
    .refetch_req(refetch_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) ncyc <= rst ? 0 : ncyc + 1;

  wire [4:0]  pulses = {srch_fetch, rd_capture, tlbwr_en, tlbfill_en, invtlb_en};
  wire [56:0] outs = {tlbwr_en, tlbfill_en, rand_index, invtlb_en, invtlb_op, invtlb_asid, invtlb_vpn,
                      srch_fetch, rd_capture, trans_busy, done_valid, done_op, done_found, done_index,
                      done_ine, refetch_req};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic txn(input int op, input int inv_op, input bit found, input int sidx, input int hold);
    int acc, c, lat;
    bit ine, refetch;
    logic [9:0] asid;
    logic [18:0] vpn;
    asid = 10'($urandom);
    vpn = 19'($urandom);
    ine = op > 4 || (op == 4 && inv_op > 6);
    refetch = !ine && op >= 2 && op <= 4;
    lat = (op == 1 || ine) ? 2 : 3;
    @(negedge clk);
    req_valid = 1; req_op = 3'(op); req_inv_op = 5'(inv_op); req_inv_asid = asid; req_inv_vpn = vpn;
    srch_found_in = found; srch_index_in = 5'(sidx);
    check("req_ready_idle", req_ready, 1);
    acc = ncyc % 32;
    @(negedge clk);
    req_valid = 0;
    check("issue_pulse", pulses, (op < 5 && !ine) ? (5'b10000 >> op) : 5'b0);
    check("rand_index", rand_index, op == 3 ? (acc + 1) % 32 : 0);
    check("busy_issue", {trans_busy, req_ready}, 2'b10);
    check("inv_latch", {invtlb_op, invtlb_asid, invtlb_vpn}, {5'(inv_op), asid, vpn});
    c = 1;
    while (c < 8) begin
      @(negedge clk);
      c++;
      check("no_extra_pulse", pulses, 0);
      if (done_valid) break;
    end
    check("latency", c, lat);
    check("done_fields", {done_op, done_found, done_index, done_ine},
          {3'(op), op == 0 && found, (op == 0 && found) ? 5'(sidx) : 5'd0, ine});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_op = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("hold_state", {done_valid, done_op, req_ready, trans_busy, refetch_req}, {1'b1, 3'(op), 1'b0, 1'b1, 1'b0});
    end
    done_ready = 1; req_valid = 1;
    #1 check("refetch", refetch_req, refetch);
    @(negedge clk);
    check("after_hs", {done_valid, trans_busy, req_ready, refetch_req}, 4'b0010);
    done_ready = 0; req_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      check("idle_outs", {req_ready, outs}, {1'b1, 57'b0});
    end
    while (ncyc % 32 != 8) @(negedge clk);
    txn(3, 0, 0, 0, 0);
    txn(0, 0, 1, 7, 1);
    txn(0, 0, 0, 7, 0);
    txn(4, 7, 0, 0, 2);
    txn(2, 0, 0, 0, 5);
    txn(5, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 1; req_op = 3'd4; req_inv_op = 5'd3; req_inv_asid = 10'h155; req_inv_vpn = 19'h12345;
    @(negedge clk);
    req_valid = 0;
    check("rst_issue_inv", invtlb_en, 1);
    @(negedge clk);
    rst = 1;
    #1 check("rst_outs", outs, 57'b0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst", {done_valid, trans_busy, req_ready}, 3'b001);
    end
    for (int n = 0; n < 200; n++)
      txn($urandom_range(0, 7), $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 3));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
